// File: rtl/serial_sub_pkg.sv
// sub_pkg: FSM state type and counter sizing shared by the serial subtractor.
package sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction
endpackage

// File: rtl/serial_sub_digit_sub.sv
// digit_sub: combinational DIGIT-bit ripple subtractor built from full subtractors.
module digit_sub #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);
  logic [DIGIT:0] c;
  assign c[0] = bin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fs
    assign d[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
  end
  assign bout = c[DIGIT];
endmodule

// File: rtl/serial_sub.sv
// serial_sub: digit-serial diff = a - b - bin, DIGIT bits per clock, start/done handshake.
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = cnt_width(NDIG);
  if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad
    $fatal(1, "serial_sub: DIGIT must divide WIDTH");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [DIGIT-1:0] d;
  logic br, bout, last, load;
  digit_sub #(.DIGIT(DIGIT)) u_dig (
    .a(a_sh[DIGIT-1:0]),
    .b(b_sh[DIGIT-1:0]),
    .bin(br),
    .d(d),
    .bout(bout)
  );
  assign last = cnt == CW'(NDIG - 1);
  assign load = start && state != RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign borrow = br;
  always_comb begin
    state_n = load ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // result digits enter at the MSB so after NDIG shifts diff is aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      diff <= '0;
      br <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      br <= bin;
      cnt <= '0;
    end else if (busy) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      diff <= WIDTH'({d, diff} >> DIGIT);
      br <= bout;
      cnt <= last ? cnt : cnt + CW'(1);
    end
  end
endmodule
